// File: rtl/circle_raster_engine.sv
// circle_raster_engine: rasterises one circle command per handshake into
// framebuffer pixel writes, filled or outlined, clipped to the screen.
module circle_raster_engine #(
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 180,
  parameter int HW        = 11,
  parameter int VW        = 10,
  parameter int RW        = 8,
  parameter int ADDR_W    = 17,
  parameter int COLOR_W   = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               data_valid_in,
  output logic               ready_out,
  input  logic [HW-1:0]      hcount_in,
  input  logic [VW-1:0]      vcount_in,
  input  logic [RW-1:0]      radius_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               mode_in,
  output logic               data_valid_out,
  input  logic               ready_in,
  output logic [HW-1:0]      hcount_out,
  output logic [VW-1:0]      vcount_out,
  output logic [ADDR_W-1:0]  addr_out,
  output logic [COLOR_W-1:0] color_out,
  output logic               done_out
);

  localparam int CW = ((HW > VW) ? HW : VW) + 2;
  localparam int SW = 2 * (RW + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2} state_t;

  state_t state_q, state_d;
  logic   done_q;
  logic   accept, issue, stall, pipe_empty, drain_done, last_cand;

  // Latched command and coordinate generator
  logic [RW:0]          cx_lo_q, cy_lo_q;
  logic [RW-1:0]        r_q;
  logic                 mode_q;
  logic [COLOR_W-1:0]   color_q;
  logic signed [CW-1:0] gx_q, gy_q, xmin_q, xmax_q, ymax_q;
  logic signed [CW-1:0] cx_ext, cy_ext, r_ext;

  // Pipeline stages
  logic                 s1_valid_q, s2_valid_q, out_valid_q;
  logic signed [CW-1:0] s1_x_q, s1_y_q;
  logic [SW-1:0]        s1_dx2_q, s1_dy2_q;
  logic [HW-1:0]        s2_x_q, out_x_q;
  logic [VW-1:0]        s2_y_q, out_y_q;
  logic [ADDR_W-1:0]    s2_addr_q, out_addr_q, addr_d;
  logic [COLOR_W-1:0]   out_color_q;

  logic [RW:0]   dx, dy, dx_mag, dy_mag;
  logic [SW-1:0] dx2, dy2, r_op, rm1_op, r2, rm1sq;
  logic [RW-1:0] rm1;
  logic [SW:0]   d2;
  logic          hit, on_screen;

  assign cx_ext = $signed({{(CW-HW){1'b0}}, hcount_in});
  assign cy_ext = $signed({{(CW-VW){1'b0}}, vcount_in});
  assign r_ext  = $signed({{(CW-RW){1'b0}}, radius_in});

  assign stall      = out_valid_q && !ready_in;
  assign accept     = data_valid_in && ready_out;
  assign pipe_empty = !s1_valid_q && !s2_valid_q && !out_valid_q;
  assign last_cand  = (gx_q == xmax_q) && (gy_q == ymax_q);

  // State register and registered completion pulse
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= drain_done;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SCAN;
      SCAN:    if (issue && last_cand) state_d = DRAIN;
      DRAIN:   if (pipe_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: command ready, candidate issue, drain completion
  always_comb begin
    ready_out  = (state_q == IDLE);
    issue      = (state_q == SCAN) && !stall;
    drain_done = (state_q == DRAIN) && pipe_empty;
  end

  // Command latch and raster-order coordinate walk
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cx_lo_q <= '0;
      cy_lo_q <= '0;
      r_q     <= '0;
      mode_q  <= 1'b0;
      color_q <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymax_q  <= '0;
    end else if (accept) begin
      cx_lo_q <= hcount_in[RW:0];
      cy_lo_q <= vcount_in[RW:0];
      r_q     <= radius_in;
      mode_q  <= mode_in;
      color_q <= color_in;
      gx_q    <= cx_ext - r_ext;
      gy_q    <= cy_ext - r_ext;
      xmin_q  <= cx_ext - r_ext;
      xmax_q  <= cx_ext + r_ext;
      ymax_q  <= cy_ext + r_ext;
    end else if (issue) begin
      if (gx_q == xmax_q) begin
        gx_q <= xmin_q;
        gy_q <= gy_q + $signed(CW'(1));
      end else begin
        gx_q <= gx_q + $signed(CW'(1));
      end
    end
  end

  // Stage 1 offsets and squares. |dx| <= r always fits RW+1 signed bits,
  // so the difference is taken modulo 2^(RW+1) on the low coordinate bits.
  always_comb begin
    dx     = gx_q[RW:0] - cx_lo_q;
    dy     = gy_q[RW:0] - cy_lo_q;
    dx_mag = dx[RW] ? -dx : dx;
    dy_mag = dy[RW] ? -dy : dy;
    dx2    = {{(RW+1){1'b0}}, dx_mag} * {{(RW+1){1'b0}}, dx_mag};
    dy2    = {{(RW+1){1'b0}}, dy_mag} * {{(RW+1){1'b0}}, dy_mag};
  end

  // Stage 2 coverage test, clipping and linear address
  always_comb begin
    r_op      = {{(RW+2){1'b0}}, r_q};
    rm1       = r_q - 1'b1;
    rm1_op    = {{(RW+2){1'b0}}, rm1};
    r2        = r_op * r_op;
    rm1sq     = rm1_op * rm1_op;
    d2        = {1'b0, s1_dx2_q} + {1'b0, s1_dy2_q};
    hit       = (d2 <= {1'b0, r2}) &&
                (!mode_q || (r_q == '0) || (d2 > {1'b0, rm1sq}));
    on_screen = !s1_x_q[CW-1] && !s1_y_q[CW-1] &&
                (s1_x_q < $signed(CW'(FB_WIDTH))) &&
                (s1_y_q < $signed(CW'(FB_HEIGHT)));
    addr_d    = ADDR_W'(s1_y_q[VW-1:0]) * ADDR_W'(FB_WIDTH) +
                ADDR_W'(s1_x_q[HW-1:0]);
  end

  // Lock-step pipeline advance; everything freezes while the output stalls
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_dx2_q    <= '0;
      s1_dy2_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_x_q      <= '0;
      s2_y_q      <= '0;
      s2_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_addr_q  <= '0;
      out_color_q <= '0;
    end else if (!stall) begin
      s1_valid_q  <= issue;
      s1_x_q      <= gx_q;
      s1_y_q      <= gy_q;
      s1_dx2_q    <= dx2;
      s1_dy2_q    <= dy2;
      s2_valid_q  <= s1_valid_q && hit && on_screen;
      s2_x_q      <= s1_x_q[HW-1:0];
      s2_y_q      <= s1_y_q[VW-1:0];
      s2_addr_q   <= addr_d;
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_x_q     <= s2_x_q;
        out_y_q     <= s2_y_q;
        out_addr_q  <= s2_addr_q;
        out_color_q <= color_q;
      end
    end
  end

  assign data_valid_out = out_valid_q;
  assign hcount_out     = out_x_q;
  assign vcount_out     = out_y_q;
  assign addr_out       = out_addr_q;
  assign color_out      = out_color_q;
  assign done_out       = done_q;

endmodule

// File: tb/tb_circle_raster_engine.sv
// Directed self-checking bench for circle_raster_engine.
module tb_circle_raster_engine;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        data_valid_in;
  logic        ready_out;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic [7:0]  radius_in;
  logic [15:0] color_in;
  logic        mode_in;
  logic        data_valid_out;
  logic        ready_in;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic [16:0] addr_out;
  logic [15:0] color_out;
  logic        done_out;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic [16:0] a;
  } pix_t;

  pix_t got[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  int fill_x[13] = '{50, 49, 50, 51, 48, 49, 50, 51, 52, 49, 50, 51, 50};
  int fill_y[13] = '{48, 49, 49, 49, 50, 50, 50, 50, 50, 51, 51, 51, 52};
  int ring_x[8]  = '{50, 49, 51, 48, 52, 49, 51, 50};
  int ring_y[8]  = '{48, 49, 49, 50, 50, 51, 51, 52};
  int org_x[6]   = '{0, 1, 2, 0, 1, 0};
  int org_y[6]   = '{0, 0, 0, 1, 1, 2};
  int bp_pat[40] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 1, 0,
                     1, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

  circle_raster_engine #(
    .FB_WIDTH (320),
    .FB_HEIGHT(180),
    .HW       (11),
    .VW       (10),
    .RW       (8),
    .ADDR_W   (17),
    .COLOR_W  (16)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .data_valid_in (data_valid_in),
    .ready_out     (ready_out),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .radius_in     (radius_in),
    .color_in      (color_in),
    .mode_in       (mode_in),
    .data_valid_out(data_valid_out),
    .ready_in      (ready_in),
    .hcount_out    (hcount_out),
    .vcount_out    (vcount_out),
    .addr_out      (addr_out),
    .color_out     (color_out),
    .done_out      (done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pix(input string tag, input int idx, input int x, input int y);
    if (idx < got.size()) begin
      chk($sformatf("%s[%0d].x", tag, idx), 32'(got[idx].x), 32'(x));
      chk($sformatf("%s[%0d].y", tag, idx), 32'(got[idx].y), 32'(y));
      chk($sformatf("%s[%0d].addr", tag, idx), 32'(got[idx].a), 32'(y * 320 + x));
    end else begin
      chk($sformatf("%s[%0d].present", tag, idx), 32'(got.size()), 32'(idx + 1));
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send_cmd(input int cx, input int cy, input int r,
                          input logic [15:0] col, input logic md);
    int n;
    n = 0;
    while (ready_out !== 1'b1 && n < 500) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk("send_ready", 32'(ready_out), 32'd1);
    hcount_in     = 11'(cx);
    vcount_in     = 10'(cy);
    radius_in     = 8'(r);
    color_in      = col;
    mode_in       = md;
    data_valid_in = 1'b1;
    @(posedge clk_in); #1;
    data_valid_in = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_out !== 1'b1 && n < budget) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk({tag, "_done"}, 32'(done_out), 32'd1);
    chk({tag, "_ready_at_done"}, 32'(ready_out), 32'd1);
  endtask

  // Output monitor: records transfers, counts done pulses, checks stall stability
  logic        prev_stall = 1'b0;
  logic [10:0] prev_h;
  logic [9:0]  prev_v;
  logic [16:0] prev_a;
  logic [15:0] prev_c;
  always @(negedge clk_in) begin
    if (rst_in) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(data_valid_out), 32'd1);
        chk("stall_h", 32'(hcount_out), 32'(prev_h));
        chk("stall_v", 32'(vcount_out), 32'(prev_v));
        chk("stall_addr", 32'(addr_out), 32'(prev_a));
        chk("stall_color", 32'(color_out), 32'(prev_c));
      end
      if (data_valid_out === 1'b1 && ready_in === 1'b1)
        got.push_back('{x: hcount_out, y: vcount_out, a: addr_out});
      if (done_out === 1'b1) done_cnt++;
      prev_stall = (data_valid_out === 1'b1) && (ready_in === 1'b0);
      prev_h = hcount_out;
      prev_v = vcount_out;
      prev_a = addr_out;
      prev_c = color_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nb;
    int  bad;
    bit  seen;
    bit  held_bad;

    rst_in = 1'b1; data_valid_in = 1'b0; ready_in = 1'b1;
    hcount_in = '0; vcount_in = '0; radius_in = '0; color_in = '0; mode_in = 1'b0;
    repeat (3) @(posedge clk_in); #1;
    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_valid", 32'(data_valid_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_h", 32'(hcount_out), 32'd0);
    chk("rst_v", 32'(vcount_out), 32'd0);
    chk("rst_addr", 32'(addr_out), 32'd0);
    chk("rst_color", 32'(color_out), 32'd0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    // Single pixel, latency of 4 cycles from the accept cycle
    got.delete();
    send_cmd(10, 10, 0, 16'hA5A5, 1'b0);
    chk("accept_drops_ready", 32'(ready_out), 32'd0);
    repeat (2) @(posedge clk_in); #1;
    chk("lat_not_yet", 32'(data_valid_out), 32'd0);
    @(posedge clk_in); #1;
    chk("lat_valid", 32'(data_valid_out), 32'd1);
    chk("single_h", 32'(hcount_out), 32'd10);
    chk("single_v", 32'(vcount_out), 32'd10);
    chk("single_addr", 32'(addr_out), 32'd3210);
    chk("single_color", 32'(color_out), 32'hA5A5);
    wait_done("single", 50);
    repeat (3) @(posedge clk_in); #1;
    chk("single_count", 32'(got.size()), 32'd1);
    chk("single_done_once", 32'(done_cnt), 32'd1);

    // Filled disc r=2
    got.delete();
    send_cmd(50, 50, 2, 16'h1111, 1'b0);
    wait_done("fill", 200);
    chk("fill_count", 32'(got.size()), 32'd13);
    for (int i = 0; i < 13; i++) chk_pix("fill", i, fill_x[i], fill_y[i]);
    if (got.size() > 4) chk("fill_addr_48_50", 32'(got[4].a), 32'd16048);

    // Outline r=2
    got.delete();
    send_cmd(50, 50, 2, 16'h2222, 1'b1);
    wait_done("ring", 200);
    chk("ring_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk_pix("ring", i, ring_x[i], ring_y[i]);

    // Clipping at the origin
    got.delete();
    send_cmd(0, 0, 2, 16'h3333, 1'b0);
    wait_done("origin", 200);
    chk("origin_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk_pix("origin", i, org_x[i], org_y[i]);

    // Clipping at the far corner: visible quarter of an r=3 disc is 11 pixels
    got.delete();
    send_cmd(319, 179, 3, 16'h4444, 1'b0);
    wait_done("corner", 200);
    chk("corner_count", 32'(got.size()), 32'd11);
    bad = 0;
    foreach (got[i]) if (got[i].x > 11'd319 || got[i].y > 10'd179) bad++;
    chk("corner_bounds", 32'(bad), 32'd0);
    chk_pix("corner", 0, 319, 176);
    chk_pix("corner", 10, 319, 179);

    // Backpressure with a second command held on the input the whole time
    got.delete();
    send_cmd(50, 50, 2, 16'h1234, 1'b0);
    hcount_in = 11'd10; vcount_in = 10'd10; radius_in = 8'd0;
    color_in = 16'hBEEF; mode_in = 1'b0; data_valid_in = 1'b1;
    seen = 1'b0; held_bad = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      ready_in = (c < 40) ? (bp_pat[c] != 0) : 1'b1;
      @(posedge clk_in); #1;
      if (done_out === 1'b1) seen = 1'b1;
      else if (ready_out !== 1'b0) held_bad = 1'b1;
    end
    ready_in = 1'b1;
    chk("bp_done", 32'(seen), 32'd1);
    chk("bp_held_off", 32'(held_bad), 32'd0);
    chk("bp_count", 32'(got.size()), 32'd13);
    for (int i = 0; i < 13; i++) chk_pix("bp", i, fill_x[i], fill_y[i]);
    @(posedge clk_in); #1;
    data_valid_in = 1'b0;
    chk("bp_b_accepted", 32'(ready_out), 32'd0);
    wait_done("bp_b", 50);
    chk("bp_b_count", 32'(got.size()), 32'd14);
    chk_pix("bp_b", 13, 10, 10);
    chk("bp_b_color", 32'(color_out), 32'hBEEF);

    // Reset in the middle of a large scan
    got.delete();
    send_cmd(100, 100, 20, 16'h0F0F, 1'b0);
    repeat (100) @(posedge clk_in); #1;
    chk("mid_busy", 32'(ready_out), 32'd0);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    chk("mid_rst_valid", 32'(data_valid_out), 32'd0);
    chk("mid_rst_ready", 32'(ready_out), 32'd1);
    nb = got.size();
    repeat (20) @(posedge clk_in); #1;
    chk("mid_no_more_pix", 32'(got.size()), 32'(nb));
    chk("mid_still_idle", 32'(data_valid_out), 32'd0);
    got.delete();
    send_cmd(20, 30, 0, 16'h00FF, 1'b1);
    wait_done("post_rst", 50);
    chk("post_rst_count", 32'(got.size()), 32'd1);
    chk_pix("post_rst", 0, 20, 30);
    chk("post_rst_color", 32'(color_out), 32'h00FF);

    repeat (3) @(posedge clk_in); #1;
    chk("done_total", 32'(done_cnt), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
